m2_block_writeback: RTL and testbench
=====================================

// Module: m2_block_writeback
// PURPOSE
//  Stage directly upstream of milestone1. Takes one 8x8 block of IDCT results from the
//  Milestone-2 dual-port RAM, clips each sample to 8 bits, packs pixel pairs into 16-bit
//  words and writes them to SRAM in the Y/U/V segment layout that milestone1 reads.
//  One start = one block; a Milestone-2 sequencer drives it and owns SRAM while it runs.
// PARAMETERS
//  Y_BASE        18'd0      SRAM word address of the Y segment
//  U_BASE        18'd38400  SRAM word address of the U segment
//  V_BASE        18'd57600  SRAM word address of the V segment
//  Y_WPR         160        SRAM words per Y image row (320 px / 2)
//  UV_WPR        80         SRAM words per U/V image row (160 px / 2)
// PORTS
//  Clock           in   1   50 MHz clock
//  Resetn          in   1   async active-low reset
//  wb_start        in   1   1-cycle pulse; starts one block (ignored while busy)
//  wb_segment      in   2   0=Y, 1=U, 2=V, 3=illegal; latched at start
//  wb_block_row    in   5   block row 0..29; latched at start
//  wb_block_col    in   6   block col (Y 0..39, U/V 0..19); latched at start
//  DP_address_a    out  6   DPRAM port A read address (even sample)
//  DP_address_b    out  6   DPRAM port B read address (odd sample)
//  DP_read_data_a  in   32  signed sample at DP_address_a, valid 1 cycle after address
//  DP_read_data_b  in   32  signed sample at DP_address_b, valid 1 cycle after address
//  SRAM_address    out  18  SRAM word address
//  SRAM_write_data out  16  {even_px[7:0], odd_px[7:0]}
//  SRAM_we_n       out  1   SRAM write enable, active low
//  wb_busy         out  1   high from accepted start until done
//  wb_done         out  1   1-cycle pulse, block finished (or rejected)
//  wb_error        out  1   high with wb_done when segment==3; else low
// BEHAVIOUR
//  Reset: all outputs 0 except SRAM_we_n=1. State S_WB_IDLE.
//  All outputs registered. DPRAM sample index = 8*row + col, row-major.
//  States: S_WB_IDLE -> S_WB_LEAD -> S_WB_WRITE (32 cycles) -> S_WB_DONE -> S_WB_IDLE.
//  S_WB_IDLE: on wb_start, seg 0..2: latch inputs, DP_address_a/b <= 0/1, compute
//   base = seg_base + row*8*WPR + col*4 (8*160 = 1024+256, 8*80 = 512+128; shift-add, no
//   multiplier), wb_busy <= 1, go to S_WB_LEAD. seg 3: wb_done & wb_error pulse next
//   cycle, no SRAM write, busy stays 0.
//  S_WB_LEAD: advance DP addresses by 2 (pair k+1), go to S_WB_WRITE.
//  S_WB_WRITE: each cycle register SRAM_we_n=0, address, packed data for pair k; issue
//   pair k+2 (addresses saturate at 62/63 after last pair). Address walk: +1 within a
//   row of 4 words; after the 4th word, address += WPR-3 (next image row).
//   32 consecutive write cycles, no bubbles.
//  S_WB_DONE: SRAM_we_n <= 1, wb_done <= 1 for 1 cycle, wb_busy <= 0, back to IDLE.
//  Latency: start sampled at edge 0; writes on cycles after edges 2..33; wb_done high
//   after edge 34. 35 cycles start-to-idle.
//  Clip: sample < 0 -> 8'd0; sample > 255 -> 8'd255; else sample[7:0]. Scaling is
//   already done upstream.
//  Address arithmetic is 18-bit, truncating. Out-of-range row/col is not checked; the
//   sequencer guarantees legal coordinates.
//  wb_start while busy: ignored, latched parameters unchanged.
//  Resetn low mid-block: abort immediately, reset values, no wb_done. Partial SRAM
//   content is left as is.
// TESTING
//  Y blk(0,0), DPRAM[i]=i -> writes addr 0..3 data 0x0001,0x0203,0x0405,0x0607;
//   addr 160..163 data 0x0809..; last write addr 1123 data 0x3E3F; done at cycle 34.
//  U blk row 1 col 2 -> first write addr 38400+640+8=39048; 4th addr 39051; 5th addr 39128.
//  V blk(29,19), DPRAM[0]=-5, [1]=300, [2]=255, [3]=0 -> addr 57600+18560+76=76236
//   data 0x00FF, then 0xFF00.
//  wb_start re-pulsed at cycle 10 of a Y block with different seg/row/col -> ignored;
//   exactly 32 writes at the original addresses, one wb_done.
//  Resetn low at cycle 15 -> we_n=1, busy=0, no done; a new start after release gives a
//   full 32-write block.
//  segment=3 -> wb_done & wb_error 1 cycle, SRAM_we_n stays 1, no DPRAM reads.

Source files
------------

// File: rtl/m2_block_writeback.sv
// Writes one 8x8 block of IDCT results from the Milestone-2 DPRAM into SRAM.
// Each sample is clipped to 8 bits and pixel pairs are packed in milestone1's Y/U/V layout.
module m2_block_writeback #(
   parameter logic [17:0] Y_BASE = 18'd0,
   parameter logic [17:0] U_BASE = 18'd38400,
   parameter logic [17:0] V_BASE = 18'd57600,
   parameter int          Y_WPR  = 160,
   parameter int          UV_WPR = 80
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        wb_start,
   input  logic [1:0]  wb_segment,
   input  logic [4:0]  wb_block_row,
   input  logic [5:0]  wb_block_col,
   output logic [5:0]  DP_address_a,
   output logic [5:0]  DP_address_b,
   input  logic [31:0] DP_read_data_a,
   input  logic [31:0] DP_read_data_b,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        wb_busy,
   output logic        wb_done,
   output logic        wb_error
);

   typedef enum logic [1:0] {
      S_WB_IDLE  = 2'd0,
      S_WB_LEAD  = 2'd1,
      S_WB_WRITE = 2'd2,
      S_WB_DONE  = 2'd3
   } wb_state_t;

   localparam logic [17:0] Y_ROW_STEP  = 18'(Y_WPR - 3);
   localparam logic [17:0] UV_ROW_STEP = 18'(UV_WPR - 3);

   wb_state_t   state_r;
   logic [1:0]  seg_r;
   logic [17:0] word_addr_r;
   logic [4:0]  pair_r;
   logic [17:0] row_s;
   logic [17:0] col_s;
   logic [17:0] base_s;
   logic [17:0] row_step_s;

   function automatic logic [7:0] clip8(input logic [31:0] sample);
      logic [7:0] result;
      if (sample[31]) begin
         result = 8'd0;
      end else if (|sample[30:8]) begin
         result = 8'd255;
      end else begin
         result = sample[7:0];
      end
      return result;
   endfunction

   // Block base address: row*8*WPR via shift-add (8*160 = 1024+256, 8*80 = 512+128)
   always_comb begin
      row_s  = {13'd0, wb_block_row};
      col_s  = {12'd0, wb_block_col};
      base_s = 18'd0;
      case (wb_segment)
         2'd0:    base_s = Y_BASE + (row_s << 10) + (row_s << 8) + (col_s << 2);
         2'd1:    base_s = U_BASE + (row_s << 9)  + (row_s << 7) + (col_s << 2);
         2'd2:    base_s = V_BASE + (row_s << 9)  + (row_s << 7) + (col_s << 2);
         default: base_s = 18'd0;
      endcase
      if (seg_r == 2'd0) begin
         row_step_s = Y_ROW_STEP;
      end else begin
         row_step_s = UV_ROW_STEP;
      end
   end

   // Sequencer: DPRAM reads run two pairs ahead of the registered SRAM write
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r         <= S_WB_IDLE;
         seg_r           <= 2'd0;
         word_addr_r     <= 18'd0;
         pair_r          <= 5'd0;
         DP_address_a    <= 6'd0;
         DP_address_b    <= 6'd0;
         SRAM_address    <= 18'd0;
         SRAM_write_data <= 16'd0;
         SRAM_we_n       <= 1'b1;
         wb_busy         <= 1'b0;
         wb_done         <= 1'b0;
         wb_error        <= 1'b0;
      end else begin
         case (state_r)
            S_WB_IDLE: begin
               SRAM_we_n <= 1'b1;
               wb_done   <= 1'b0;
               wb_error  <= 1'b0;
               if (wb_start) begin
                  if (wb_segment == 2'd3) begin
                     wb_done  <= 1'b1;
                     wb_error <= 1'b1;
                  end else begin
                     seg_r        <= wb_segment;
                     word_addr_r  <= base_s;
                     pair_r       <= 5'd0;
                     DP_address_a <= 6'd0;
                     DP_address_b <= 6'd1;
                     wb_busy      <= 1'b1;
                     state_r      <= S_WB_LEAD;
                  end
               end
            end
            S_WB_LEAD: begin
               DP_address_a <= 6'd2;
               DP_address_b <= 6'd3;
               state_r      <= S_WB_WRITE;
            end
            S_WB_WRITE: begin
               SRAM_we_n       <= 1'b0;
               SRAM_address    <= word_addr_r;
               SRAM_write_data <= {clip8(DP_read_data_a), clip8(DP_read_data_b)};
               if (pair_r[1:0] == 2'd3) begin
                  word_addr_r <= word_addr_r + row_step_s;
               end else begin
                  word_addr_r <= word_addr_r + 18'd1;
               end
               if (DP_address_a != 6'd62) begin
                  DP_address_a <= DP_address_a + 6'd2;
                  DP_address_b <= DP_address_b + 6'd2;
               end
               pair_r <= pair_r + 5'd1;
               if (pair_r == 5'd31) begin
                  state_r <= S_WB_DONE;
               end
            end
            S_WB_DONE: begin
               SRAM_we_n <= 1'b1;
               wb_done   <= 1'b1;
               wb_busy   <= 1'b0;
               state_r   <= S_WB_IDLE;
            end
            default: begin
               state_r <= S_WB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m2_block_writeback.sv
// Self-checking bench for m2_block_writeback: DPRAM and SRAM models plus a
// reference that computes each write's address and packed data from the block layout.
module tb_m2_block_writeback;

   logic        Clock;
   logic        Resetn;
   logic        wb_start;
   logic [1:0]  wb_segment;
   logic [4:0]  wb_block_row;
   logic [5:0]  wb_block_col;
   logic [5:0]  DP_address_a;
   logic [5:0]  DP_address_b;
   logic [31:0] DP_read_data_a;
   logic [31:0] DP_read_data_b;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic        wb_busy;
   logic        wb_done;
   logic        wb_error;

   int n_checks;
   int n_fail;

   int mem [0:63];

   logic [17:0] wr_addr [$];
   logic [15:0] wr_data [$];
   int          wr_edge [$];
   int          done_edge;
   int          done_cnt;
   logic        err_at_done;
   logic        busy_at_start;

   m2_block_writeback dut (
      .Clock           (Clock),
      .Resetn          (Resetn),
      .wb_start        (wb_start),
      .wb_segment      (wb_segment),
      .wb_block_row    (wb_block_row),
      .wb_block_col    (wb_block_col),
      .DP_address_a    (DP_address_a),
      .DP_address_b    (DP_address_b),
      .DP_read_data_a  (DP_read_data_a),
      .DP_read_data_b  (DP_read_data_b),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n),
      .wb_busy         (wb_busy),
      .wb_done         (wb_done),
      .wb_error        (wb_error)
   );

   initial begin
      Clock = 1'b0;
      forever #10 Clock = ~Clock;
   end

   // Dual-port RAM with one cycle of read latency
   always @(posedge Clock) begin
      DP_read_data_a <= mem[DP_address_a];
      DP_read_data_b <= mem[DP_address_b];
   end

   function automatic logic [7:0] clip_ref(input int v);
      if (v < 0) return 8'd0;
      else if (v > 255) return 8'd255;
      else return 8'(v);
   endfunction

   function automatic logic [17:0] model_addr(input int s, input int r, input int c, input int k);
      int base;
      int wpr;
      wpr  = (s == 0) ? 160 : 80;
      base = (s == 0) ? 0 : ((s == 1) ? 38400 : 57600);
      return 18'(base + r * 8 * wpr + c * 4 + (k / 4) * wpr + (k % 4));
   endfunction

   function automatic logic [15:0] model_data(input int k);
      return {clip_ref(mem[2 * k]), clip_ref(mem[2 * k + 1])};
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 64; i++) begin
         case ($urandom_range(0, 3))
            0:       mem[i] = int'($urandom);
            1:       mem[i] = int'($urandom_range(0, 255));
            2:       mem[i] = -int'($urandom_range(1, 1000));
            default: mem[i] = 256 + int'($urandom_range(0, 2000));
         endcase
      end
   endtask

   // Starts one block and records every SRAM write until two cycles after wb_done
   task automatic run_block(input logic [1:0] s, input logic [4:0] r, input logic [5:0] c,
                            input int restart_edge);
      wr_addr.delete();
      wr_data.delete();
      wr_edge.delete();
      done_edge   = -1;
      done_cnt    = 0;
      err_at_done = 1'b0;
      @(negedge Clock);
      wb_start     = 1'b1;
      wb_segment   = s;
      wb_block_row = r;
      wb_block_col = c;
      @(posedge Clock);
      #1;
      wb_start      = 1'b0;
      busy_at_start = wb_busy;
      if (wb_done) begin
         done_edge   = 0;
         done_cnt++;
         err_at_done = wb_error;
      end
      for (int e = 1; e <= 60; e++) begin
         if (e == restart_edge) begin
            wb_start     = 1'b1;
            wb_segment   = 2'd2;
            wb_block_row = 5'd7;
            wb_block_col = 6'd1;
         end
         @(posedge Clock);
         #1;
         wb_start = 1'b0;
         if (!SRAM_we_n) begin
            wr_addr.push_back(SRAM_address);
            wr_data.push_back(SRAM_write_data);
            wr_edge.push_back(e);
         end
         if (wb_done) begin
            done_cnt++;
            if (done_edge < 0) begin
               done_edge   = e;
               err_at_done = wb_error;
            end
         end
         if (done_edge >= 0 && e >= done_edge + 2) break;
      end
   endtask

   task automatic test_reset();
      Resetn       = 1'b0;
      wb_start     = 1'b0;
      wb_segment   = 2'd0;
      wb_block_row = 5'd0;
      wb_block_col = 6'd0;
      for (int i = 0; i < 64; i++) mem[i] = 0;
      repeat (3) @(posedge Clock);
      #1;
      n_checks++;
      if ({SRAM_we_n, wb_busy, wb_done, wb_error} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got we_n/busy/done/err %b, expected 1000",
                  {SRAM_we_n, wb_busy, wb_done, wb_error});
      end
      n_checks++;
      if ({SRAM_address, SRAM_write_data, DP_address_a, DP_address_b} !== 46'd0) begin
         n_fail++;
         $display("FAIL reset_data: got addr %0d data %h dpa %0d dpb %0d, expected all 0",
                  SRAM_address, SRAM_write_data, DP_address_a, DP_address_b);
      end
      @(negedge Clock);
      Resetn = 1'b1;
   endtask

   task automatic test_illegal_segment();
      run_block(2'd3, 5'd5, 6'd7, -1);
      n_checks++;
      if (done_edge !== 0 || err_at_done !== 1'b1) begin
         n_fail++;
         $display("FAIL seg3_done: got done edge %0d err %b, expected edge 0 err 1", done_edge, err_at_done);
      end
      n_checks++;
      if (done_cnt !== 1 || busy_at_start !== 1'b0) begin
         n_fail++;
         $display("FAIL seg3_pulse: got %0d dones busy %b, expected 1 done busy 0", done_cnt, busy_at_start);
      end
      n_checks++;
      if (wr_addr.size() !== 0 || DP_address_a !== 6'd0 || DP_address_b !== 6'd0) begin
         n_fail++;
         $display("FAIL seg3_quiet: got %0d writes dpa %0d dpb %0d, expected 0 writes dpa 0 dpb 0",
                  wr_addr.size(), DP_address_a, DP_address_b);
      end
      n_checks++;
      if (wb_error !== 1'b0) begin
         n_fail++;
         $display("FAIL seg3_err_clear: got err %b, expected 0", wb_error);
      end
   endtask

   task automatic test_y_ramp();
      for (int i = 0; i < 64; i++) mem[i] = i;
      run_block(2'd0, 5'd0, 6'd0, -1);
      n_checks++;
      if (wr_addr.size() !== 32 || busy_at_start !== 1'b1 || err_at_done !== 1'b0) begin
         n_fail++;
         $display("FAIL y_count: got %0d writes busy %b err %b, expected 32 writes busy 1 err 0",
                  wr_addr.size(), busy_at_start, err_at_done);
      end
      n_checks++;
      if (done_edge !== 34) begin
         n_fail++;
         $display("FAIL y_done_edge: got %0d, expected 34", done_edge);
      end
      if (wr_addr.size() == 32) begin
         n_checks++;
         if (wr_addr[0] !== 18'd0 || wr_data[0] !== 16'h0001 || wr_addr[3] !== 18'd3 || wr_data[3] !== 16'h0607) begin
            n_fail++;
            $display("FAIL y_first_row: got %0d/%h %0d/%h, expected 0/0001 3/0607",
                     wr_addr[0], wr_data[0], wr_addr[3], wr_data[3]);
         end
         n_checks++;
         if (wr_addr[4] !== 18'd160 || wr_data[4] !== 16'h0809) begin
            n_fail++;
            $display("FAIL y_second_row: got %0d/%h, expected 160/0809", wr_addr[4], wr_data[4]);
         end
         n_checks++;
         if (wr_addr[31] !== 18'd1123 || wr_data[31] !== 16'h3E3F) begin
            n_fail++;
            $display("FAIL y_last: got %0d/%h, expected 1123/3e3f", wr_addr[31], wr_data[31]);
         end
         n_checks++;
         if (wr_edge[0] !== 2 || wr_edge[31] !== 33) begin
            n_fail++;
            $display("FAIL y_write_window: got edges %0d..%0d, expected 2..33", wr_edge[0], wr_edge[31]);
         end
      end
   endtask

   task automatic test_u_offsets();
      fill_random();
      run_block(2'd1, 5'd1, 6'd2, -1);
      n_checks++;
      if (wr_addr.size() !== 32) begin
         n_fail++;
         $display("FAIL u_count: got %0d writes, expected 32", wr_addr.size());
      end else begin
         n_checks++;
         if (wr_addr[0] !== 18'd39048 || wr_addr[3] !== 18'd39051 || wr_addr[4] !== 18'd39128) begin
            n_fail++;
            $display("FAIL u_addr: got %0d %0d %0d, expected 39048 39051 39128",
                     wr_addr[0], wr_addr[3], wr_addr[4]);
         end
         for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (wr_addr[k] !== model_addr(1, 1, 2, k) || wr_data[k] !== model_data(k)) begin
               n_fail++;
               $display("FAIL u_write[%0d]: got %0d/%h, expected %0d/%h", k,
                        wr_addr[k], wr_data[k], model_addr(1, 1, 2, k), model_data(k));
            end
         end
      end
   endtask

   task automatic test_v_clip();
      fill_random();
      mem[0] = -5;
      mem[1] = 300;
      mem[2] = 255;
      mem[3] = 0;
      run_block(2'd2, 5'd29, 6'd19, -1);
      n_checks++;
      if (wr_addr.size() !== 32) begin
         n_fail++;
         $display("FAIL v_count: got %0d writes, expected 32", wr_addr.size());
      end else begin
         n_checks++;
         if (wr_addr[0] !== 18'd76236 || wr_data[0] !== 16'h00FF || wr_data[1] !== 16'hFF00) begin
            n_fail++;
            $display("FAIL v_clip: got %0d/%h then %h, expected 76236/00ff then ff00",
                     wr_addr[0], wr_data[0], wr_data[1]);
         end
         for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (wr_addr[k] !== model_addr(2, 29, 19, k) || wr_data[k] !== model_data(k)) begin
               n_fail++;
               $display("FAIL v_write[%0d]: got %0d/%h, expected %0d/%h", k,
                        wr_addr[k], wr_data[k], model_addr(2, 29, 19, k), model_data(k));
            end
         end
      end
   endtask

   task automatic test_restart_ignored();
      fill_random();
      run_block(2'd0, 5'd3, 6'd5, 10);
      n_checks++;
      if (wr_addr.size() !== 32 || done_cnt !== 1 || done_edge !== 34) begin
         n_fail++;
         $display("FAIL restart_shape: got %0d writes %0d dones at edge %0d, expected 32 writes 1 done at 34",
                  wr_addr.size(), done_cnt, done_edge);
      end
      for (int k = 0; k < 32 && k < wr_addr.size(); k++) begin
         n_checks++;
         if (wr_addr[k] !== model_addr(0, 3, 5, k) || wr_data[k] !== model_data(k)) begin
            n_fail++;
            $display("FAIL restart_write[%0d]: got %0d/%h, expected %0d/%h", k,
                     wr_addr[k], wr_data[k], model_addr(0, 3, 5, k), model_data(k));
         end
      end
   endtask

   task automatic test_reset_mid_block();
      logic saw_done;
      fill_random();
      @(negedge Clock);
      wb_start     = 1'b1;
      wb_segment   = 2'd0;
      wb_block_row = 5'd2;
      wb_block_col = 6'd4;
      @(posedge Clock);
      #1;
      wb_start = 1'b0;
      repeat (14) begin
         @(posedge Clock);
         #1;
      end
      Resetn = 1'b0;
      #1;
      n_checks++;
      if (SRAM_we_n !== 1'b1 || wb_busy !== 1'b0 || wb_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: got we_n %b busy %b done %b, expected 1 0 0", SRAM_we_n, wb_busy, wb_done);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge Clock);
         #1;
         if (wb_done) saw_done = 1'b1;
      end
      @(negedge Clock);
      Resetn = 1'b1;
      repeat (2) begin
         @(posedge Clock);
         #1;
         if (wb_done) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: got done %b, expected 0", saw_done);
      end
      fill_random();
      run_block(2'd1, 5'd10, 6'd15, -1);
      n_checks++;
      if (wr_addr.size() !== 32 || done_edge !== 34) begin
         n_fail++;
         $display("FAIL abort_recover: got %0d writes done edge %0d, expected 32 and 34", wr_addr.size(), done_edge);
      end
      for (int k = 0; k < 32 && k < wr_addr.size(); k++) begin
         n_checks++;
         if (wr_addr[k] !== model_addr(1, 10, 15, k) || wr_data[k] !== model_data(k)) begin
            n_fail++;
            $display("FAIL recover_write[%0d]: got %0d/%h, expected %0d/%h", k,
                     wr_addr[k], wr_data[k], model_addr(1, 10, 15, k), model_data(k));
         end
      end
   endtask

   task automatic test_random_blocks();
      int s;
      int r;
      int c;
      for (int n = 0; n < 8; n++) begin
         fill_random();
         s = int'($urandom_range(0, 2));
         r = int'($urandom_range(0, 29));
         c = (s == 0) ? int'($urandom_range(0, 39)) : int'($urandom_range(0, 19));
         run_block(2'(s), 5'(r), 6'(c), -1);
         n_checks++;
         if (wr_addr.size() !== 32 || done_edge !== 34 || done_cnt !== 1 || err_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_shape[%0d]: got %0d writes done edge %0d count %0d err %b, expected 32 34 1 0",
                     n, wr_addr.size(), done_edge, done_cnt, err_at_done);
         end
         for (int k = 0; k < 32 && k < wr_addr.size(); k++) begin
            n_checks++;
            if (wr_addr[k] !== model_addr(s, r, c, k) || wr_data[k] !== model_data(k) || wr_edge[k] !== k + 2) begin
               n_fail++;
               $display("FAIL rand_write[%0d.%0d]: got %0d/%h at edge %0d, expected %0d/%h at edge %0d", n, k,
                        wr_addr[k], wr_data[k], wr_edge[k], model_addr(s, r, c, k), model_data(k), k + 2);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_illegal_segment();
      test_y_ramp();
      test_u_offsets();
      test_v_clip();
      test_restart_ignored();
      test_reset_mid_block();
      test_random_blocks();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
